// File: rtl/settings_access_ctrl_pkg.sv
// Shared types for the settings memory access controller: FSM states,
// requester identities and the address-window legality check.
package settings_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      RESP  = 3'd4
   } state_t;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_t;

   // ROM words are read-only; anything past the RAM window is illegal.
   function automatic logic addr_err(input logic [31:0] addr,
                                     input logic        wen,
                                     input int unsigned rom_len,
                                     input int unsigned total_len);
      return (addr >= total_len) || (wen && (addr < rom_len));
   endfunction

endpackage

// File: rtl/settings_access_ctrl_if.sv
// Request/response channels for requesters A and B plus the settings memory port.
// The slave modport is the controller's view; master is the requesters' and memory's view.
interface settings_access_ctrl_if #(
   parameter int AW = 5,
   parameter int DW = 16
);
   logic          a_req_valid;
   logic          a_req_ready;
   logic          a_req_wen;
   logic [AW-1:0] a_req_addr;
   logic [DW-1:0] a_req_wdata;
   logic          a_rsp_valid;
   logic [DW-1:0] a_rsp_rdata;
   logic          a_rsp_err;

   logic          b_req_valid;
   logic          b_req_ready;
   logic          b_req_wen;
   logic [AW-1:0] b_req_addr;
   logic [DW-1:0] b_req_wdata;
   logic          b_rsp_valid;
   logic [DW-1:0] b_rsp_rdata;
   logic          b_rsp_err;

   logic          mem_wen;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  a_req_valid, a_req_wen, a_req_addr, a_req_wdata,
      output a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err,
      input  b_req_valid, b_req_wen, b_req_addr, b_req_wdata,
      output b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err,
      output mem_wen, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output a_req_valid, a_req_wen, a_req_addr, a_req_wdata,
      input  a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err,
      output b_req_valid, b_req_wen, b_req_addr, b_req_wdata,
      input  b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err,
      input  mem_wen, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/settings_access_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant while enabled, zero latency.
// On a tie the requester not granted last wins; last grant resets to B.
module settings_rr_arbiter2
   import settings_ctrl_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    en_i,
   input  logic    req_a_i,
   input  logic    req_b_i,
   output logic    gnt_a_o,
   output logic    gnt_b_o,
   output req_id_t gnt_id_o
);
   req_id_t last_q, last_d;

   assign gnt_a_o  = en_i && req_a_i && (!req_b_i || (last_q == REQ_B));
   assign gnt_b_o  = en_i && req_b_i && (!req_a_i || (last_q == REQ_A));
   assign gnt_id_o = gnt_b_o ? REQ_B : REQ_A;

   always_comb begin
      last_d = last_q;
      if (gnt_a_o) begin
         last_d = REQ_A;
      end else if (gnt_b_o) begin
         last_d = REQ_B;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= REQ_B;
      end else begin
         last_q <= last_d;
      end
   end
endmodule

// File: rtl/settings_access_ctrl.sv
// Shares the ROM+RAM settings memory between requesters A and B, one transaction at a time.
// Response: error T+2, write T+3, read T+3+MEM_RD_LATENCY; non-grantee held off until IDLE.
module settings_access_ctrl
   import settings_ctrl_pkg::*;
#(
   parameter  int MEMORY_WIDTH      = 16,
   parameter  int ROM_MEMORY_LENGTH = 16,
   parameter  int RAM_MEMORY_LENGTH = 16,
   parameter  int MEM_RD_LATENCY    = 1,
   localparam int AW = $clog2(ROM_MEMORY_LENGTH + RAM_MEMORY_LENGTH)
)(
   input  logic                  clk,
   input  logic                  rstb,
   settings_access_ctrl_if.slave bus,
   output logic                  busy
);
   localparam int CW = (MEM_RD_LATENCY > 1) ? $clog2(MEM_RD_LATENCY) : 1;
   localparam int unsigned TOTAL_LEN = ROM_MEMORY_LENGTH + RAM_MEMORY_LENGTH;

   state_t                  state_q, state_d;
   req_id_t                 gnt_q, gnt_d;
   logic                    wen_q, wen_d;
   logic [AW-1:0]           addr_q, addr_d;
   logic [MEMORY_WIDTH-1:0] wdata_q, wdata_d;
   logic                    err_q, err_d;
   logic [MEMORY_WIDTH-1:0] rdata_q, rdata_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    mem_wen_q, mem_wen_d;
   logic [AW-1:0]           mem_addr_q, mem_addr_d;
   logic [MEMORY_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

   logic    gnt_a, gnt_b, rsp_a, rsp_b;
   req_id_t gnt_id;

   settings_rr_arbiter2 u_arb (
      .clk      (clk),
      .rst      (rstb),
      .en_i     (state_q == IDLE),
      .req_a_i  (bus.a_req_valid),
      .req_b_i  (bus.b_req_valid),
      .gnt_a_o  (gnt_a),
      .gnt_b_o  (gnt_b),
      .gnt_id_o (gnt_id)
   );

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      wen_d       = wen_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      rdata_d     = rdata_q;
      cnt_d       = cnt_q;
      mem_wen_d   = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         IDLE: begin
            if (gnt_a || gnt_b) begin
               gnt_d   = gnt_id;
               wen_d   = gnt_b ? bus.b_req_wen   : bus.a_req_wen;
               addr_d  = gnt_b ? bus.b_req_addr  : bus.a_req_addr;
               wdata_d = gnt_b ? bus.b_req_wdata : bus.a_req_wdata;
               err_d   = 1'b0;
               rdata_d = '0;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (addr_err(32'(addr_q), wen_q, ROM_MEMORY_LENGTH, TOTAL_LEN)) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               mem_addr_d  = addr_q;
               mem_wdata_d = wdata_q;
               mem_wen_d   = wen_q;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (wen_q) begin
               state_d = RESP;
            end else begin
               cnt_d   = CW'(MEM_RD_LATENCY - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            // mem_addr has been presented since ISSUE; count is the remaining latency.
            if (cnt_q == '0) begin
               rdata_d = bus.mem_rdata;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstb) begin
         state_q     <= IDLE;
         gnt_q       <= REQ_A;
         wen_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         cnt_q       <= '0;
         mem_wen_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         wen_q       <= wen_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         cnt_q       <= cnt_d;
         mem_wen_q   <= mem_wen_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign rsp_a = (state_q == RESP) && (gnt_q == REQ_A);
   assign rsp_b = (state_q == RESP) && (gnt_q == REQ_B);

   assign bus.a_req_ready = gnt_a;
   assign bus.b_req_ready = gnt_b;
   assign bus.a_rsp_valid = rsp_a;
   assign bus.b_rsp_valid = rsp_b;
   assign bus.a_rsp_rdata = rsp_a ? rdata_q : '0;
   assign bus.b_rsp_rdata = rsp_b ? rdata_q : '0;
   assign bus.a_rsp_err   = rsp_a && err_q;
   assign bus.b_rsp_err   = rsp_b && err_q;
   assign bus.mem_wen     = mem_wen_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign busy            = (state_q != IDLE);
endmodule

// File: tb/tb_settings_access_ctrl.sv
// Directed bench: dut0 is ROM16/RAM16/latency 1, dut1 is ROM16/RAM8/latency 3.
module tb_settings_access_ctrl;
   localparam int AW = 5;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rstb;
   logic busy0, busy1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   settings_access_ctrl_if #(.AW(AW), .DW(DW)) bus0 ();
   settings_access_ctrl_if #(.AW(AW), .DW(DW)) bus1 ();

   settings_access_ctrl #(.MEMORY_WIDTH(16), .ROM_MEMORY_LENGTH(16),
                          .RAM_MEMORY_LENGTH(16), .MEM_RD_LATENCY(1))
      u_dut0 (.clk(clk), .rstb(rstb), .bus(bus0), .busy(busy0));

   settings_access_ctrl #(.MEMORY_WIDTH(16), .ROM_MEMORY_LENGTH(16),
                          .RAM_MEMORY_LENGTH(8), .MEM_RD_LATENCY(3))
      u_dut1 (.clk(clk), .rstb(rstb), .bus(bus1), .busy(busy1));

   // Memory models: ROM words 0xA000+i, RAM words 0xC000+i.
   logic [15:0] mem0 [32];
   logic [15:0] mem1 [32];
   logic [15:0] rd0, p1, p2, p3;
   logic        init_done = 1'b0;

   function automatic logic [15:0] init_word(input int i);
      return (i < 16) ? 16'(32'hA000 + i) : 16'(32'hC000 + i);
   endfunction

   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 32; i++) begin
            mem0[i] <= init_word(i);
            mem1[i] <= init_word(i);
         end
         init_done <= 1'b1;
      end else begin
         if (bus0.mem_wen) mem0[bus0.mem_addr] <= bus0.mem_wdata;
         if (bus1.mem_wen) mem1[bus1.mem_addr] <= bus1.mem_wdata;
      end
      rd0 <= mem0[bus0.mem_addr];
      p1  <= mem1[bus1.mem_addr];
      p2  <= p1;
      p3  <= p2;
   end

   assign bus0.mem_rdata = rd0;
   assign bus1.mem_rdata = p3;

   task automatic drive(input bit inst, input bit pb, input logic v, input logic w,
                        input logic [4:0] a, input logic [15:0] d);
      if (!inst && !pb) begin
         bus0.a_req_valid = v; bus0.a_req_wen = w; bus0.a_req_addr = a; bus0.a_req_wdata = d;
      end else if (!inst) begin
         bus0.b_req_valid = v; bus0.b_req_wen = w; bus0.b_req_addr = a; bus0.b_req_wdata = d;
      end else if (!pb) begin
         bus1.a_req_valid = v; bus1.a_req_wen = w; bus1.a_req_addr = a; bus1.a_req_wdata = d;
      end else begin
         bus1.b_req_valid = v; bus1.b_req_wen = w; bus1.b_req_addr = a; bus1.b_req_wdata = d;
      end
   endtask

   task automatic peek(input bit inst, input bit pb, output logic rdy, output logic own,
                       output logic oth, output logic e, output logic [15:0] rd,
                       output logic mw, output logic [4:0] ma);
      if (!inst) begin
         rdy = pb ? bus0.b_req_ready : bus0.a_req_ready;
         own = pb ? bus0.b_rsp_valid : bus0.a_rsp_valid;
         oth = pb ? bus0.a_rsp_valid : bus0.b_rsp_valid;
         e   = pb ? bus0.b_rsp_err   : bus0.a_rsp_err;
         rd  = pb ? bus0.b_rsp_rdata : bus0.a_rsp_rdata;
         mw  = bus0.mem_wen;
         ma  = bus0.mem_addr;
      end else begin
         rdy = pb ? bus1.b_req_ready : bus1.a_req_ready;
         own = pb ? bus1.b_rsp_valid : bus1.a_rsp_valid;
         oth = pb ? bus1.a_rsp_valid : bus1.b_rsp_valid;
         e   = pb ? bus1.b_rsp_err   : bus1.a_rsp_err;
         rd  = pb ? bus1.b_rsp_rdata : bus1.a_rsp_rdata;
         mw  = bus1.mem_wen;
         ma  = bus1.mem_addr;
      end
   endtask

   // One transaction; times are cycles after the accept cycle (-1 = never seen).
   task automatic xact(input bit inst, input bit pb, input logic w, input logic [4:0] a,
                       input logic [15:0] d, output int rsp_t, output logic e,
                       output logic [15:0] rd, output int wen_n, output int wen_t,
                       output int oth_n, output bit moved);
      logic rdy, own, oth, pe, pmw;
      logic [15:0] prd;
      logic [4:0] pma;
      bit got;
      rsp_t = -1; e = 1'b0; rd = '0; wen_n = 0; wen_t = -1; oth_n = 0; moved = 1'b0; got = 1'b0;
      @(posedge clk); #1;
      drive(inst, pb, 1'b1, w, a, d);
      for (int i = 0; i < 20 && !got; i++) begin
         #1;
         peek(inst, pb, rdy, own, oth, pe, prd, pmw, pma);
         if (rdy) got = 1'b1;
         else begin @(posedge clk); #1; end
      end
      if (!got) begin
         drive(inst, pb, 1'b0, 1'b0, 5'd0, 16'd0);
         return;
      end
      for (int t = 1; t <= 20; t++) begin
         @(posedge clk); #1;
         if (t == 1) drive(inst, pb, 1'b0, 1'b0, 5'd0, 16'd0);
         #1;
         peek(inst, pb, rdy, own, oth, pe, prd, pmw, pma);
         if (pmw) begin wen_n++; wen_t = t; end
         if (oth) oth_n++;
         if (own) begin rsp_t = t; e = pe; rd = prd; break; end
         if (t >= 2 && pma != a) moved = 1'b1;
      end
   endtask

   task automatic test_reset();
      logic [60:0] v0, v1;
      v0 = {bus0.a_req_ready, bus0.a_rsp_valid, bus0.a_rsp_err, bus0.a_rsp_rdata,
            bus0.b_req_ready, bus0.b_rsp_valid, bus0.b_rsp_err, bus0.b_rsp_rdata,
            bus0.mem_wen, bus0.mem_addr, bus0.mem_wdata, busy0};
      v1 = {bus1.a_req_ready, bus1.a_rsp_valid, bus1.a_rsp_err, bus1.a_rsp_rdata,
            bus1.b_req_ready, bus1.b_rsp_valid, bus1.b_rsp_err, bus1.b_rsp_rdata,
            bus1.mem_wen, bus1.mem_addr, bus1.mem_wdata, busy1};
      checks++; if (v0 !== '0) begin errors++; $display("FAIL reset_outputs_dut0 got %h want 0", v0); end
      checks++; if (v1 !== '0) begin errors++; $display("FAIL reset_outputs_dut1 got %h want 0", v1); end
   endtask

   task automatic test_ram_write_read();
      int rt, wn, wt, on; logic e; logic [15:0] rd; bit mv;
      xact(1'b0, 1'b0, 1'b1, 5'd16, 16'hBEEF, rt, e, rd, wn, wt, on, mv);
      checks++; if (rt !== 3) begin errors++; $display("FAIL wr16_latency got %0d want 3", rt); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr16_err got %b want 0", e); end
      checks++; if (wn !== 1 || wt !== 2) begin errors++; $display("FAIL wr16_wen_pulse got n=%0d t=%0d want n=1 t=2", wn, wt); end
      checks++; if (mem0[16] !== 16'hBEEF) begin errors++; $display("FAIL wr16_mem got %h want beef", mem0[16]); end
      checks++; if (on !== 0) begin errors++; $display("FAIL wr16_other_rsp got %0d want 0", on); end
      xact(1'b0, 1'b0, 1'b0, 5'd16, 16'h0000, rt, e, rd, wn, wt, on, mv);
      checks++; if (rt !== 4) begin errors++; $display("FAIL rd16_latency got %0d want 4", rt); end
      checks++; if (rd !== 16'hBEEF || e !== 1'b0) begin errors++; $display("FAIL rd16_data got %h err=%b want beef err=0", rd, e); end
      checks++; if (wn !== 0) begin errors++; $display("FAIL rd16_wen got %0d want 0", wn); end
   endtask

   task automatic test_rom_protect();
      int rt, wn, wt, on; logic e; logic [15:0] rd; bit mv;
      xact(1'b0, 1'b1, 1'b1, 5'd3, 16'h1234, rt, e, rd, wn, wt, on, mv);
      checks++; if (rt !== 2) begin errors++; $display("FAIL rom_wr_latency got %0d want 2", rt); end
      checks++; if (e !== 1'b1 || rd !== 16'h0000) begin errors++; $display("FAIL rom_wr_rsp got err=%b rd=%h want err=1 rd=0", e, rd); end
      checks++; if (wn !== 0) begin errors++; $display("FAIL rom_wr_wen got %0d want 0", wn); end
      checks++; if (on !== 0) begin errors++; $display("FAIL rom_wr_other_rsp got %0d want 0", on); end
      xact(1'b0, 1'b0, 1'b0, 5'd3, 16'h0000, rt, e, rd, wn, wt, on, mv);
      checks++; if (rt !== 4 || rd !== 16'hA003 || e !== 1'b0) begin errors++; $display("FAIL rom_rd got t=%0d rd=%h err=%b want t=4 rd=a003 err=0", rt, rd, e); end
   endtask

   task automatic test_boundaries();
      int rt, wn, wt, on; logic e; logic [15:0] rd; bit mv;
      xact(1'b0, 1'b1, 1'b1, 5'd31, 16'h7777, rt, e, rd, wn, wt, on, mv);
      checks++; if (rt !== 3 || e !== 1'b0 || wn !== 1) begin errors++; $display("FAIL wr31 got t=%0d err=%b wen=%0d want t=3 err=0 wen=1", rt, e, wn); end
      xact(1'b0, 1'b1, 1'b0, 5'd31, 16'h0000, rt, e, rd, wn, wt, on, mv);
      checks++; if (rd !== 16'h7777 || e !== 1'b0) begin errors++; $display("FAIL rd31 got %h err=%b want 7777 err=0", rd, e); end
      xact(1'b0, 1'b0, 1'b1, 5'd15, 16'h5A5A, rt, e, rd, wn, wt, on, mv);
      checks++; if (rt !== 2 || e !== 1'b1 || wn !== 0) begin errors++; $display("FAIL wr15 got t=%0d err=%b wen=%0d want t=2 err=1 wen=0", rt, e, wn); end
   endtask

   task automatic test_fairness();
      int seq [8];
      int g = 0, nrsp = 0, na = 0, nb = 0, nbr = 0;
      bit acc_a = 1'b0, acc_b = 1'b0;
      for (int i = 0; i < 8; i++) seq[i] = -1;
      @(posedge clk); #1 rstb = 1'b1;
      @(posedge clk); #1 rstb = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd20, 16'h0100);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd20, 16'h0000);
      for (int cyc = 0; cyc < 200 && nrsp < 8; cyc++) begin
         #1;
         if (bus0.a_req_ready) begin if (g < 8) seq[g] = 0; g++; acc_a = 1'b1; end
         if (bus0.b_req_ready) begin if (g < 8) seq[g] = 1; g++; acc_b = 1'b1; end
         if (bus0.a_rsp_valid && bus0.b_rsp_valid) begin
            checks++; errors++; $display("FAIL fair_dual_rsp got both pulses want one");
         end
         if (bus0.a_rsp_valid) begin
            checks++;
            if (nrsp >= 8 || seq[nrsp] !== 0) begin errors++; $display("FAIL fair_a_owner rsp %0d got A want other", nrsp); end
            nrsp++;
         end
         if (bus0.b_rsp_valid) begin
            checks++;
            if (nrsp >= 8 || seq[nrsp] !== 1) begin errors++; $display("FAIL fair_b_owner rsp %0d got B want other", nrsp); end
            checks++;
            if (bus0.b_rsp_rdata !== 16'(32'h0100 + nbr)) begin
               errors++; $display("FAIL fair_b_rdata %0d got %h want %h", nbr, bus0.b_rsp_rdata, 16'(32'h0100 + nbr));
            end
            nbr++; nrsp++;
         end
         @(posedge clk); #1;
         if (acc_a) begin
            acc_a = 1'b0; na++;
            if (na < 4) bus0.a_req_wdata = 16'(32'h0100 + na); else bus0.a_req_valid = 1'b0;
         end
         if (acc_b) begin
            acc_b = 1'b0; nb++;
            if (nb >= 4) bus0.b_req_valid = 1'b0;
         end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 16'd0);
      checks++; if (nrsp !== 8 || g !== 8) begin errors++; $display("FAIL fair_count got rsp=%0d grants=%0d want 8 8", nrsp, g); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (seq[i] !== (i % 2)) begin errors++; $display("FAIL fair_order grant %0d got %0d want %0d", i, seq[i], i % 2); end
      end
   endtask

   task automatic test_range_latency3();
      int rt, wn, wt, on; logic e; logic [15:0] rd; bit mv;
      xact(1'b1, 1'b0, 1'b0, 5'd24, 16'h0000, rt, e, rd, wn, wt, on, mv);
      checks++; if (rt !== 2 || e !== 1'b1 || rd !== 16'h0000) begin errors++; $display("FAIL rd24 got t=%0d err=%b rd=%h want t=2 err=1 rd=0", rt, e, rd); end
      checks++; if (wn !== 0) begin errors++; $display("FAIL rd24_wen got %0d want 0", wn); end
      xact(1'b1, 1'b1, 1'b0, 5'd23, 16'h0000, rt, e, rd, wn, wt, on, mv);
      checks++; if (rt !== 6) begin errors++; $display("FAIL rd23_latency got %0d want 6", rt); end
      checks++; if (rd !== 16'hC017 || e !== 1'b0) begin errors++; $display("FAIL rd23_data got %h err=%b want c017 err=0", rd, e); end
      checks++; if (mv !== 1'b0) begin errors++; $display("FAIL rd23_addr_stable got moved=%b want 0", mv); end
   endtask

   task automatic test_reset_mid_op();
      int rt, wn, wt, on, pulses; logic e; logic [15:0] rd; bit mv, got;
      logic [60:0] v1;
      got = 1'b0; pulses = 0;
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd16, 16'h0000);
      for (int i = 0; i < 20 && !got; i++) begin
         #1;
         if (bus1.a_req_ready) got = 1'b1; else begin @(posedge clk); #1; end
      end
      checks++; if (!got) begin errors++; $display("FAIL rst_mid_accept got no ready want ready"); end
      for (int t = 1; t <= 3; t++) begin
         @(posedge clk); #1;
         if (t == 1) drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
         if (bus1.a_rsp_valid || bus1.b_rsp_valid) pulses++;
      end
      checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_in_wait got %b want 1", busy1); end
      rstb = 1'b1;
      @(posedge clk); #1;
      rstb = 1'b0;
      v1 = {bus1.a_req_ready, bus1.a_rsp_valid, bus1.a_rsp_err, bus1.a_rsp_rdata,
            bus1.b_req_ready, bus1.b_rsp_valid, bus1.b_rsp_err, bus1.b_rsp_rdata,
            bus1.mem_wen, bus1.mem_addr, bus1.mem_wdata, busy1};
      checks++; if (v1 !== '0) begin errors++; $display("FAIL rst_mid_outputs got %h want 0", v1); end
      for (int t = 0; t < 6; t++) begin
         @(posedge clk); #1;
         if (bus1.a_rsp_valid || bus1.b_rsp_valid) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_mid_no_rsp got %0d pulses want 0", pulses); end
      xact(1'b1, 1'b1, 1'b1, 5'd18, 16'h5555, rt, e, rd, wn, wt, on, mv);
      checks++; if (rt !== 3 || e !== 1'b0) begin errors++; $display("FAIL post_rst_b_wr got t=%0d err=%b want t=3 err=0", rt, e); end
      checks++; if (mem1[18] !== 16'h5555) begin errors++; $display("FAIL post_rst_mem got %h want 5555", mem1[18]); end
   endtask

   initial begin
      rstb = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 16'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 16'd0);
      repeat (3) @(posedge clk);
      #1 rstb = 1'b0;
      test_reset();
      test_ram_write_read();
      test_rom_protect();
      test_boundaries();
      test_fairness();
      test_range_latency3();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish want finish");
      $fatal(1, "watchdog");
   end
endmodule
